// File: rtl/tdm_demultiplexer_pkg.sv
// Shared constants and state encoding for the TDM link (transmit and receive sides).
// Latency: n/a (package only).
// Backpressure: n/a; the link is valid-only, with no ready path.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds a trailing even-parity beat per frame).
package tdm_pkg;

    localparam int DEF_CHANNELS = 8;

`ifdef TDM_DEMUX_PARITY_EN
    // The slot counter must also be able to represent CHANNELS while the parity beat is pending.
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_CHANNELS + 1);
`else
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_CHANNELS);
`endif

    // XOR over all data bits plus the parity bit must equal this value (even parity).
    localparam logic PARITY_EVEN = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        PARITY = 2'd2
    } tdm_state_e;

endpackage

// File: rtl/tdm_demultiplexer_if.sv
// Link-side inputs and parallel-side outputs of the TDM demultiplexer, bundled as one interface.
// Latency: n/a (wiring only).
// Backpressure: none; serial_valid qualifies each beat and there is no ready signal.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds parity_error).
interface tdm_demultiplexer_if
    import tdm_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  serial_in;
    logic                  serial_valid;
    logic                  frame_start;
    logic [ADDR_WIDTH-1:0] address;
    logic [CHANNELS-1:0]   parallel_out;
    logic                  frame_valid;
    logic                  sync_error;
    logic                  busy;
`ifdef TDM_DEMUX_PARITY_EN
    logic                  parity_error;
`endif

    // The link driver or environment side.
    modport master (
        output serial_in, serial_valid, frame_start,
        input  address, parallel_out, frame_valid, sync_error, busy
`ifdef TDM_DEMUX_PARITY_EN
        , parity_error
`endif
    );

    // The demultiplexer side.
    modport slave (
        input  serial_in, serial_valid, frame_start,
        output address, parallel_out, frame_valid, sync_error, busy
`ifdef TDM_DEMUX_PARITY_EN
        , parity_error
`endif
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot counter: tracks which slot the next accepted beat lands in, and flags the last data slot.
// Latency: address updates one clock after a control input is asserted.
// Backpressure: none; the counter holds whenever no control input is asserted.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_i,
    input  logic                  load_one_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;

    // Next address: clear has priority over load-to-1, which has priority over increment.
    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (load_one_i) begin
            addr_d = ADDR_WIDTH'(1);
        end else if (inc_i) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
    end

    // Address register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign address_o = addr_q;
    assign last_o    = (addr_q == ADDR_WIDTH'(CHANNELS - 1));

endmodule

// File: rtl/tdm_demultiplexer.sv
// Rebuilds parallel CHANNELS-bit words from a slot-ordered TDM bit stream, with frame alignment and sync-error reporting.
// Latency: parallel_out and frame_valid appear one clock after the frame's final accepted beat.
// Backpressure: none; serial_valid low holds all state, and gaps of any length are tolerated.
// Optional feature macro: TDM_DEMUX_PARITY_EN (trailing even-parity beat and a parity_error pulse).
module tdm_demultiplexer
    import tdm_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic                clk,
    input logic                reset_n,
    tdm_demultiplexer_if.slave link
);

    // Reject parameter sets where the slot counter cannot represent every reachable value.
    if (CHANNELS < 2) begin : g_bad_channels
        $error("tdm_demultiplexer: CHANNELS must be at least 2");
    end
`ifdef TDM_DEMUX_PARITY_EN
    if (ADDR_WIDTH < $clog2(CHANNELS + 1)) begin : g_bad_addr_width
        $error("tdm_demultiplexer: ADDR_WIDTH must cover CHANNELS when parity is enabled");
    end
`else
    if (ADDR_WIDTH != $clog2(CHANNELS)) begin : g_bad_addr_width
        $error("tdm_demultiplexer: ADDR_WIDTH must equal $clog2(CHANNELS)");
    end
`endif

    tdm_state_e            state_q;
    tdm_state_e            state_d;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last_slot;
    logic                  cnt_clr;
    logic                  cnt_load_one;
    logic                  cnt_inc;
    logic                  wr_slot0;      // beat opens a frame and lands in slot 0
    logic                  wr_addr;       // beat lands in the slot the counter points at
    logic                  complete;      // frame finishes on this beat
    logic                  sync_err_d;
    logic [CHANNELS-1:0]   shadow_q;
    logic [CHANNELS-1:0]   shadow_d;
    logic [CHANNELS-1:0]   parallel_q;
    logic [CHANNELS-1:0]   frame_word;
    logic                  frame_valid_q;
    logic                  sync_error_q;
`ifdef TDM_DEMUX_PARITY_EN
    logic                  parity_bad;
    logic                  parity_err_d;
    logic                  parity_error_q;
`endif

    tdm_slot_counter #(
        .CHANNELS   (CHANNELS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_slot_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (cnt_clr),
        .load_one_i (cnt_load_one),
        .inc_i      (cnt_inc),
        .address_o  (addr),
        .last_o     (last_slot)
    );

`ifdef TDM_DEMUX_PARITY_EN
    // The parity beat follows the data, so the whole word is already in the shadow register.
    assign frame_word = shadow_q;
    assign parity_bad = (((^shadow_q) ^ link.serial_in) != PARITY_EVEN);
`else
    // The final data bit is merged straight in, so the word is delivered on the last beat's edge.
    assign frame_word = {link.serial_in, shadow_q[CHANNELS-2:0]};
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-beat control; a beat with frame_start always restarts at slot 0.
    always_comb begin
        state_d      = state_q;
        cnt_clr      = 1'b0;
        cnt_load_one = 1'b0;
        cnt_inc      = 1'b0;
        wr_slot0     = 1'b0;
        wr_addr      = 1'b0;
        complete     = 1'b0;
        sync_err_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (link.serial_valid && link.frame_start) begin
                    wr_slot0     = 1'b1;
                    cnt_load_one = 1'b1;
                    state_d      = RECV;
                end
            end
            RECV: begin
                if (link.serial_valid) begin
                    if (link.frame_start) begin
                        sync_err_d   = 1'b1;
                        wr_slot0     = 1'b1;
                        cnt_load_one = 1'b1;
                    end else if (last_slot) begin
                        wr_addr = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                        cnt_inc = 1'b1;
                        state_d = PARITY;
`else
                        cnt_clr  = 1'b1;
                        complete = 1'b1;
                        state_d  = IDLE;
`endif
                    end else begin
                        wr_addr = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
`ifdef TDM_DEMUX_PARITY_EN
            PARITY: begin
                if (link.serial_valid) begin
                    if (link.frame_start) begin
                        sync_err_d   = 1'b1;
                        wr_slot0     = 1'b1;
                        cnt_load_one = 1'b1;
                        state_d      = RECV;
                    end else begin
                        complete     = 1'b1;
                        parity_err_d = parity_bad;
                        cnt_clr      = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
`endif
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Steer the received bit into its slot of the shadow word.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((wr_slot0 && (i == 0)) || (wr_addr && (addr == ADDR_WIDTH'(i)))) begin
                shadow_d[i] = link.serial_in;
            end
        end
    end

    // Shadow word, delivered word and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q       <= '0;
            parallel_q     <= '0;
            frame_valid_q  <= 1'b0;
            sync_error_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_error_q <= 1'b0;
`endif
        end else begin
            shadow_q       <= shadow_d;
            if (complete) begin
                parallel_q <= frame_word;
            end
            frame_valid_q  <= complete;
            sync_error_q   <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            parity_error_q <= parity_err_d;
`endif
        end
    end

    assign link.address      = addr;
    assign link.parallel_out = parallel_q;
    assign link.frame_valid  = frame_valid_q;
    assign link.sync_error   = sync_error_q;
    assign link.busy         = (state_q != IDLE);
`ifdef TDM_DEMUX_PARITY_EN
    assign link.parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Bench for tdm_demultiplexer: directed frames followed by random beats, checked against a frame-level model.
// Latency: n/a (testbench).
// Backpressure: n/a; random gaps are driven on serial_valid.
module tb_tdm_demultiplexer;
    import tdm_pkg::*;

    localparam int CH = DEF_CHANNELS;
    localparam int AW = DEF_ADDR_WIDTH;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    tdm_demultiplexer_if #(.CHANNELS(CH), .ADDR_WIDTH(AW)) link();

    tdm_demultiplexer #(.CHANNELS(CH), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .link    (link)
    );

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Frame-level reference: a list of bits received so far, plus the last delivered word.
    int            m_nbits;
    logic          m_in_par;
    logic [CH-1:0] m_bits;
    logic [CH-1:0] m_out;
    logic          m_fv;
    logic          m_se;
    logic          m_pe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_nbits  = 0;
        m_in_par = 1'b0;
        m_bits   = '0;
        m_out    = '0;
        m_fv     = 1'b0;
        m_se     = 1'b0;
        m_pe     = 1'b0;
    endtask

    task automatic model_beat(input logic v, input logic fs, input logic d);
        m_fv = 1'b0;
        m_se = 1'b0;
        m_pe = 1'b0;
        if (v) begin
            if (fs) begin
                if (m_nbits > 0 || m_in_par) m_se = 1'b1;
                m_bits    = '0;
                m_bits[0] = d;
                m_nbits   = 1;
                m_in_par  = 1'b0;
            end else if (m_in_par) begin
                m_out    = m_bits;
                m_fv     = 1'b1;
                m_pe     = ((^m_bits) ^ d);
                m_in_par = 1'b0;
                m_nbits  = 0;
            end else if (m_nbits > 0) begin
                m_bits[m_nbits] = d;
                m_nbits++;
                if (m_nbits == CH) begin
`ifdef TDM_DEMUX_PARITY_EN
                    m_in_par = 1'b1;
`else
                    m_out   = m_bits;
                    m_fv    = 1'b1;
                    m_nbits = 0;
`endif
                end
            end
        end
    endtask

    task automatic check_model();
        chk("address",      32'(link.address),      m_in_par ? 32'(CH) : 32'(m_nbits));
        chk("parallel_out", 32'(link.parallel_out), 32'(m_out));
        chk("frame_valid",  32'(link.frame_valid),  32'(m_fv));
        chk("sync_error",   32'(link.sync_error),   32'(m_se));
        chk("busy",         32'(link.busy),         32'((m_nbits > 0) || m_in_par));
`ifdef TDM_DEMUX_PARITY_EN
        chk("parity_error", 32'(link.parity_error), 32'(m_pe));
`endif
    endtask

    // One clock: drive the beat, let the edge happen, then compare just after it.
    task automatic beat(input logic v, input logic fs, input logic d);
        link.serial_valid = v;
        link.frame_start  = fs;
        link.serial_in    = d;
        @(posedge clk);
        model_beat(v, fs, d);
        #1;
        check_model();
    endtask

    task automatic send_bits(input logic [CH-1:0] w, input int from, input int to);
        for (int i = from; i < to; i++) beat(1'b1, (i == 0), w[i]);
    endtask

    task automatic finish_frame(input logic [CH-1:0] w);
`ifdef TDM_DEMUX_PARITY_EN
        beat(1'b1, 1'b0, ^w);
`else
        if (w === 'x) $error("FAIL finish_frame: unknown word");
`endif
    endtask

    task automatic idle();
        beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    logic [CH-1:0] w;

    initial begin
        reset_n           = 1'b0;
        link.serial_in    = 1'b0;
        link.serial_valid = 1'b0;
        link.frame_start  = 1'b0;
        model_reset();
        #2;
        phase = "reset";
        check_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();

        phase = "single_a5";
        w = 8'hA5;
        send_bits(w, 0, CH);
        finish_frame(w);
        chk("fv", 32'(link.frame_valid), 32'd1);
        chk("out", 32'(link.parallel_out), 32'hA5);
        chk("se", 32'(link.sync_error), 32'd0);
        chk("busy", 32'(link.busy), 32'd0);
        idle();
        chk("fv_pulse", 32'(link.frame_valid), 32'd0);

        phase = "gap_a5";
        send_bits(w, 0, 4);
        repeat (3) begin
            idle();
            chk("gap_addr", 32'(link.address), 32'd4);
        end
        send_bits(w, 4, CH);
        finish_frame(w);
        chk("fv", 32'(link.frame_valid), 32'd1);
        chk("out", 32'(link.parallel_out), 32'hA5);

        phase = "restart_3c";
        w = 8'hFF;
        send_bits(w, 0, 5);
        w = 8'h3C;
        beat(1'b1, 1'b1, w[0]);
        chk("se", 32'(link.sync_error), 32'd1);
        chk("out_held", 32'(link.parallel_out), 32'hA5);
        chk("addr", 32'(link.address), 32'd1);
        send_bits(w, 1, CH);
        finish_frame(w);
        chk("fv", 32'(link.frame_valid), 32'd1);
        chk("out", 32'(link.parallel_out), 32'h3C);

        phase = "back_to_back";
        w = 8'hFF;
        send_bits(w, 0, CH);
        finish_frame(w);
        chk("fv_ff", 32'(link.frame_valid), 32'd1);
        chk("out_ff", 32'(link.parallel_out), 32'hFF);
        w = 8'h00;
        send_bits(w, 0, CH);
        finish_frame(w);
        chk("fv_00", 32'(link.frame_valid), 32'd1);
        chk("out_00", 32'(link.parallel_out), 32'h00);

        phase = "async_reset";
        w = 8'h5A;
        send_bits(w, 0, CH);
        finish_frame(w);
        w = 8'h81;
        send_bits(w, 0, 6);
        chk("addr_pre", 32'(link.address), 32'd6);
        link.serial_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("out_rst", 32'(link.parallel_out), 32'd0);
        chk("addr_rst", 32'(link.address), 32'd0);
        chk("busy_rst", 32'(link.busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        w = 8'h42;
        send_bits(w, 0, CH);
        finish_frame(w);
        chk("out_42", 32'(link.parallel_out), 32'h42);

`ifdef TDM_DEMUX_PARITY_EN
        phase = "parity";
        w = 8'h07;
        send_bits(w, 0, CH);
        chk("addr_par", 32'(link.address), 32'(CH));
        beat(1'b1, 1'b0, 1'b1);
        chk("pe_ok", 32'(link.parity_error), 32'd0);
        chk("out_ok", 32'(link.parallel_out), 32'h07);
        send_bits(w, 0, CH);
        beat(1'b1, 1'b0, 1'b0);
        chk("pe_bad", 32'(link.parity_error), 32'd1);
        chk("fv_bad", 32'(link.frame_valid), 32'd1);
        chk("out_bad", 32'(link.parallel_out), 32'h07);
`endif

        phase = "rand_frames";
        repeat (30) begin
            w = CH'($urandom);
            for (int i = 0; i < CH; i++) begin
                while ($urandom_range(0, 3) == 0) idle();
                beat(1'b1, (i == 0), w[i]);
            end
            if ($urandom_range(0, 1) == 1) begin
`ifdef TDM_DEMUX_PARITY_EN
                beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
`endif
            end else begin
                finish_frame(w);
            end
        end

        phase = "rand_beats";
        repeat (800) begin
            beat(($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demultiplexer.md
Name: tdm_demultiplexer

Overview:
- Receive end of the time-division-multiplexed serial link driven by the scanning structural multiplexer.
- The transmitter walks its select address 0..CHANNELS-1 and emits in[address] one bit per beat.
- This block rebuilds the parallel word by steering each received bit into the output slot given by its own slot counter.
- Sits between the link and downstream parallel consumers, with frame alignment, gap tolerance and sync-error reporting.

Parameters:
- CHANNELS, 8, number of slots per frame (>=2); slot i maps to parallel_out[i].
- ADDR_WIDTH, 3, slot-counter width; must equal $clog2(CHANNELS).

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  link data bit for the current beat.
- serial_valid  input  1  beat qualifier; a beat is accepted only when high.
- frame_start  input  1  marks the accepted beat as slot 0; meaningful only with serial_valid.
- address  output  ADDR_WIDTH  slot index the next accepted beat will be written to.
- parallel_out  output  CHANNELS  last completed frame; holds until the next frame completes.
- frame_valid  output  1  one-cycle pulse; parallel_out has just been updated.
- sync_error  output  1  one-cycle pulse; frame_start arrived before the current frame completed.
- busy  output  1  high while a frame is partially received (state != IDLE).

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, address=0, shadow register=0, parallel_out=0.
  - frame_valid=0, sync_error=0, busy=0.
- State IDLE:
  - Beat with frame_start=1: write serial_in to shadow[0], address<=1, go to RECV.
  - Beat with frame_start=0: ignored; no error is raised.
  - frame_start without serial_valid: ignored.
- State RECV, beat with frame_start=0:
  - shadow[address]<=serial_in, address<=address+1.
- State RECV, beat with frame_start=1:
  - Partial frame is discarded and sync_error pulses.
  - The beat becomes slot 0 of a new frame: shadow[0]<=serial_in, address<=1, state stays RECV.
  - parallel_out is unchanged.
- Final slot (address==CHANNELS-1, beat accepted, no frame_start):
  - Same edge: parallel_out<={serial_in, shadow[CHANNELS-2:0]}, frame_valid<=1, address<=0, state<=IDLE.
  - Outputs are visible the cycle after the last bit's edge, so latency is 1 clock from the final beat.
- Gaps: serial_valid=0 holds all state; gaps of any length are legal mid-frame.
- Back-to-back frames: frame_start on the beat immediately after the final slot is accepted with no idle cycle required.
- Pulse outputs: frame_valid and sync_error are high for exactly one cycle and default low otherwise. They never assert on the same cycle without the parity feature.
- Width rule: address wraps only via the final-slot rule, never by natural overflow; values >=CHANNELS are unreachable.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - After the final data slot the FSM enters PARITY instead of IDLE, and address reads CHANNELS.
  - ADDR_WIDTH must then cover CHANNELS; the parameter check is enforced by assertion.
  - The next accepted beat is an even-parity bit: XOR of all data bits and the parity bit must be 0.
  - On that beat, parallel_out updates, frame_valid pulses, and the new output parity_error (1 bit) pulses with frame_valid on mismatch.
  - Data is delivered even on a parity mismatch.
  - frame_start during PARITY: sync_error pulses, the frame is dropped, and the beat starts a new frame.
  - Reset value of parity_error is 0.
- Undefined: no PARITY state, no parity_error port; behaviour exactly as above.

Decomposition:
- Shared package tdm_pkg:
  - State encoding: IDLE=2'd0, RECV=2'd1, PARITY=2'd2.
  - Default CHANNELS and ADDR_WIDTH constants.
  - The parity-polarity constant, so the transmitter side reuses the same values.
- One natural sub-module, tdm_slot_counter:
  - Async-reset counter with load-to-1, increment-on-enable and clear-to-0 controls.
  - Outputs address and a last-slot flag.

Test Plan:
- Single frame 0xA5, bits sent slot0 first (1,0,1,0,0,1,0,1), frame_start on first beat -> frame_valid one cycle after the 8th beat, parallel_out=0xA5, sync_error=0, busy back to 0.
- Same 0xA5 frame with serial_valid low for 3 cycles between slots 3 and 4 -> address holds at 4 during the gap, result 0xA5, no error.
- Send 5 bits of a frame, then frame_start with frame 0x3C -> sync_error pulse on the restart beat, parallel_out stays at the previous value, then 0x3C with frame_valid.
- Frames 0xFF and 0x00 back-to-back with no gap -> two frame_valid pulses 8 cycles apart, parallel_out 0xFF then 0x00.
- Assert reset_n low at slot 6 of frame 0x81, release, send 0x42 -> outputs 0 immediately on reset without waiting for clk, old frame lost, parallel_out=0x42.
- With TDM_DEMUX_PARITY_EN, send 0x07 with parity 1, then 0x07 with parity 0 -> first frame: parity_error=0; second frame: parity_error=1; both deliver 0x07.
